// File: rtl/tdm_mux_8x1_pkg.sv
// Shared definitions for the TDM 8:1 serializer: FSM state encodings and default channel count.
package tdm_mux_8x1_pkg;

    typedef logic [0:0] tdm_state_t;

    localparam tdm_state_t ST_IDLE = 1'b0;
    localparam tdm_state_t ST_SEND = 1'b1;

    localparam int unsigned TDM_N_CH_DEFAULT = 8;

endpackage

// File: rtl/tdm_mux_8x1_if.sv
// Frame-in / serial-out bundle of the TDM serializer; the slave modport is the serializer side.
interface tdm_mux_8x1_if #(
    parameter int unsigned N_CH = tdm_mux_8x1_pkg::TDM_N_CH_DEFAULT
);
    localparam int unsigned SEL_W = $clog2(N_CH);

    logic             en;
    logic [N_CH-1:0]  d_in;
    logic             d_valid;
    logic             d_ready;
    logic             y;
    logic             y_valid;
    logic [SEL_W-1:0] sel;
    logic             sof;
    logic             eof;

    modport master (
        output en, d_in, d_valid,
        input  d_ready, y, y_valid, sel, sof, eof
    );

    modport slave (
        input  en, d_in, d_valid,
        output d_ready, y, y_valid, sel, sof, eof
    );

endinterface

// File: rtl/tdm_sel_counter.sv
// Modulo-N_CH channel index counter with clear, load-to-first-index, direction and terminal flags.
module tdm_sel_counter #(
    parameter int unsigned N_CH      = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned SEL_W    = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic             load_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             first_o,
    output logic             last_o,
    output logic             in_range_o
);

    localparam logic [SEL_W-1:0] TOP_IDX   = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? TOP_IDX : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : TOP_IDX;

    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = FIRST_IDX;
        end else if (step_i) begin
            if (MSB_FIRST) begin
                cnt_d = (cnt_q == '0) ? TOP_IDX : cnt_q - SEL_W'(1);
            end else begin
                cnt_d = (cnt_q == TOP_IDX) ? '0 : cnt_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign first_o = (cnt_q == FIRST_IDX);
    assign last_o  = (cnt_q == LAST_IDX);

    // A power-of-two channel count leaves no unused codes to guard against.
    if ((1 << SEL_W) == N_CH) begin : g_full_range
        assign in_range_o = 1'b1;
    end else begin : g_part_range
        assign in_range_o = (cnt_q <= TOP_IDX);
    end

endmodule

// File: rtl/tdm_mux_8x1.sv
// Time-division N_CH:1 serializer: accepts one parallel frame, emits one channel per enabled clock.
module tdm_mux_8x1
    import tdm_mux_8x1_pkg::*;
#(
    parameter int unsigned N_CH      = TDM_N_CH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    tdm_mux_8x1_if.slave  bus
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    tdm_state_t       state_q, state_d;
    logic [N_CH-1:0]  frame_q, frame_d;
    logic [SEL_W-1:0] sel;
    logic             first, last, in_range;
    logic             ctr_step, ctr_load, ctr_clr;
    logic             sending, d_ready, accept;

    tdm_sel_counter #(
        .N_CH      (N_CH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sel_counter (
        .clk        (clk),
        .rst        (rst),
        .step_i     (ctr_step),
        .load_i     (ctr_load),
        .clr_i      (ctr_clr),
        .cnt_o      (sel),
        .first_o    (first),
        .last_o     (last),
        .in_range_o (in_range)
    );

    assign sending = (state_q == ST_SEND);
    assign d_ready = bus.en & ~rst & (~sending | last);
    assign accept  = bus.d_valid & d_ready;

    // Accept takes priority at the last channel so back-to-back frames leave no gap.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        ctr_step = 1'b0;
        ctr_load = 1'b0;
        ctr_clr  = 1'b0;
        if (bus.en) begin
            if (accept) begin
                state_d  = ST_SEND;
                frame_d  = bus.d_in;
                ctr_load = 1'b1;
            end else if (sending && (last || !in_range)) begin
                state_d = ST_IDLE;
                ctr_clr = 1'b1;
            end else if (sending) begin
                ctr_step = 1'b1;
            end else begin
                ctr_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    assign bus.d_ready = d_ready;
    assign bus.y       = sending & frame_q[sel];
    assign bus.y_valid = sending;
    assign bus.sel     = sel;
    assign bus.sof     = sending & first;
    assign bus.eof     = sending & last;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Bench for tdm_mux_8x1: LSB-first and MSB-first instances checked against a frame-position model.
module tb_tdm_mux_8x1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       d_valid;
    logic [7:0] d_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_mux_8x1_if #(.N_CH(8)) bus0 ();
    tdm_mux_8x1_if #(.N_CH(8)) bus1 ();

    assign bus0.en = en;
    assign bus0.d_in = d_in;
    assign bus0.d_valid = d_valid;
    assign bus1.en = en;
    assign bus1.d_in = d_in;
    assign bus1.d_valid = d_valid;

    tdm_mux_8x1 #(.N_CH(8), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    tdm_mux_8x1 #(.N_CH(8), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Model: a frame is busy for 8 positions; position p puts channel p (or 7-p) on the line.
    bit         m_busy [2];
    logic [7:0] m_frame[2];
    int         m_pos  [2];

    function automatic logic [2:0] m_idx(int k);
        return (k == 1) ? 3'(7 - m_pos[k]) : 3'(m_pos[k]);
    endfunction

    // {y_valid, sel[2:0], y, sof, eof}
    function automatic logic [6:0] m_out(int k);
        logic [2:0] i;
        if (!m_busy[k]) return 7'd0;
        i = m_idx(k);
        return {1'b1, i, m_frame[k][i], m_pos[k] == 0, m_pos[k] == 7};
    endfunction

    function automatic logic m_ready(int k);
        return en & ~rst & (!m_busy[k] || m_pos[k] == 7);
    endfunction

    function automatic logic [6:0] obs(int k);
        if (k == 0) return {bus0.y_valid, bus0.sel, bus0.y, bus0.sof, bus0.eof};
        return {bus1.y_valid, bus1.sel, bus1.y, bus1.sof, bus1.eof};
    endfunction

    function automatic logic obs_ready(int k);
        return (k == 0) ? bus0.d_ready : bus1.d_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_pos[k] = 0;
            m_frame[k] = 8'h00;
        end
    endtask

    task automatic model_edge();
        bit acc[2];
        for (int k = 0; k < 2; k++) acc[k] = (d_valid === 1'b1) && (m_ready(k) === 1'b1);
        if (rst) begin
            model_reset();
        end else if (en) begin
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    m_busy[k] = 1'b1;
                    m_frame[k] = d_in;
                    m_pos[k] = 0;
                end else if (m_busy[k] && m_pos[k] == 7) begin
                    m_busy[k] = 1'b0;
                    m_pos[k] = 0;
                end else if (m_busy[k]) begin
                    m_pos[k]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; d_valid = 1'b0; d_in = 8'h00;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({obs(k), obs_ready(k)} !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got %b want 00000000", k, {obs(k), obs_ready(k)});
            end
        end
        en = 1'b1;
        #1;
        n_cmp++;
        if (bus0.d_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_en: got %b want 0", bus0.d_ready);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({bus0.d_ready, bus1.d_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL release_ready: got %b want 11", {bus0.d_ready, bus1.d_ready});
        end
    endtask

    task automatic test_single_frame();
        logic exp_y[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        d_in = 8'b1010_0110; d_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus0.d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 1", bus0.d_ready);
        end
        step();
        d_valid = 1'b0; d_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs(0) !== {1'b1, 3'(i), exp_y[i], i == 0, i == 7}) begin
                n_bad++;
                $display("FAIL single_ch%0d: got %b want %b", i, obs(0), {1'b1, 3'(i), exp_y[i], i == 0, i == 7});
            end
            n_cmp++;
            if (obs(1) !== m_out(1)) begin
                n_bad++;
                $display("FAIL single_msb_ch%0d: got %b want %b", i, obs(1), m_out(1));
            end
            step();
        end
        n_cmp++;
        if ({obs(0), bus0.d_ready} !== 8'b0000_0001) begin
            n_bad++;
            $display("FAIL single_after: got %b want 00000001", {obs(0), bus0.d_ready});
        end
    endtask

    task automatic test_back_to_back();
        d_in = 8'hFF; d_valid = 1'b1;
        step();
        d_in = 8'h00;
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (obs(0) !== {1'b1, 3'(c % 8), c < 8, c == 0 || c == 8, c == 7 || c == 15}) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d: got %b want %b", c + 1, obs(0),
                         {1'b1, 3'(c % 8), c < 8, c == 0 || c == 8, c == 7 || c == 15});
            end
            n_cmp++;
            if (obs(1) !== m_out(1)) begin
                n_bad++;
                $display("FAIL b2b_msb_cycle%0d: got %b want %b", c + 1, obs(1), m_out(1));
            end
            if (c == 8) d_valid = 1'b0;
            step();
        end
        n_cmp++;
        if (obs(0) !== 7'd0) begin
            n_bad++;
            $display("FAIL b2b_after: got %b want 0000000", obs(0));
        end
    endtask

    task automatic test_stall();
        logic [7:0] f = 8'h5A;
        d_in = f; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        repeat (3) step();
        en = 1'b0; d_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++;
            if ({bus0.d_ready, bus1.d_ready} !== 2'b00) begin
                n_bad++;
                $display("FAIL stall_ready%0d: got %b want 00", s, {bus0.d_ready, bus1.d_ready});
            end
            step();
            n_cmp++;
            if (obs(0) !== {1'b1, 3'd3, f[3], 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got %b want %b", s, obs(0), {1'b1, 3'd3, f[3], 1'b0, 1'b0});
            end
        end
        en = 1'b1; d_valid = 1'b0;
        step();
        n_cmp++;
        if (obs(0) !== {1'b1, 3'd4, f[4], 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_resume: got %b want %b", obs(0), {1'b1, 3'd4, f[4], 1'b0, 1'b0});
        end
        repeat (4) step();
    endtask

    task automatic test_async_reset();
        logic exp_y[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d_in = 8'h5A; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (bus0.sel !== 3'd5) begin
            n_bad++;
            $display("FAIL arst_pre_sel: got %0d want 5", bus0.sel);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({obs(k), obs_ready(k)} !== 8'h00) begin
                n_bad++;
                $display("FAIL arst_outputs dut%0d: got %b want 00000000", k, {obs(k), obs_ready(k)});
            end
        end
        model_reset();
        #1 rst = 1'b0;
        step();
        d_in = 8'h3C; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs(0) !== {1'b1, 3'(i), exp_y[i], i == 0, i == 7}) begin
                n_bad++;
                $display("FAIL arst_frame_ch%0d: got %b want %b", i, obs(0), {1'b1, 3'(i), exp_y[i], i == 0, i == 7});
            end
            n_cmp++;
            if (obs(1) !== m_out(1)) begin
                n_bad++;
                $display("FAIL arst_msb_ch%0d: got %b want %b", i, obs(1), m_out(1));
            end
            step();
        end
    endtask

    // Receive side: a 1-to-8 demux writes y into bit sel whenever y_valid is high.
    task automatic test_loopback();
        logic [7:0] bytes[2] = '{8'h5A, 8'hC3};
        logic [7:0] rebuilt[2];
        for (int b = 0; b < 2; b++) begin
            rebuilt[0] = 8'h00; rebuilt[1] = 8'h00;
            d_in = bytes[b]; d_valid = 1'b1;
            step();
            d_valid = 1'b0;
            for (int c = 0; c < 9; c++) begin
                if (bus0.y_valid === 1'b1) rebuilt[0][bus0.sel] = bus0.y;
                if (bus1.y_valid === 1'b1) rebuilt[1][bus1.sel] = bus1.y;
                step();
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (rebuilt[k] !== bytes[b]) begin
                    n_bad++;
                    $display("FAIL loopback dut%0d byte%0d: got %h want %h", k, b, rebuilt[k], bytes[b]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 9) != 0);
            d_valid = 1'($urandom_range(0, 1));
            d_in = 8'($urandom);
            if (rst) model_reset();
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ({obs(k), obs_ready(k)} !== {m_out(k), m_ready(k)}) begin
                    n_bad++;
                    $display("FAIL random dut%0d cycle%0d: got %b want %b", k, c,
                             {obs(k), obs_ready(k)}, {m_out(k), m_ready(k)});
                end
            end
            step();
        end
        rst = 1'b0; en = 1'b1; d_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
